// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and default operand width for the bit-serial adder/subtractor.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder, purely combinational; shared by every bit position of the serial datapath.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first: done pulses WIDTH+1 edges after an accepted start.
// No backpressure; start is honoured only in IDLE and is dropped while busy or done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < 2) begin : g_width_check
    $error("serial_adder: WIDTH must be at least 2");
  end

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic             fa_s, fa_co;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1, so the operand inversion and forced carry happen at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b ^ {WIDTH{sub}};
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
          carry  <= fa_co;
          cnt    <= cnt + CW'(1);
          // Publish only the finished word so the visible result never ripples mid-operation.
          if (last) begin
            sum_q  <= {fa_s, sum_sh[WIDTH-1:1]};
            cout_q <= fa_co;
            ovf_q  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors, start/reset corner cases, random ops vs model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, overflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] esum;
    logic       ecout;
    logic       eovf;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference from integer arithmetic: unsigned result for sum/cout, signed range test for overflow.
  function automatic logic [9:0] ref_op(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rcin, input logic rsub);
    int         ua, ub, sa, sb, ures, sres;
    logic [7:0] rs;
    logic       rc, rv;
    ua = int'(ra);
    ub = int'(rb);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (rsub) begin
      ures = ua - ub;
      sres = sa - sb;
      rc   = (ua >= ub);
    end else begin
      ures = ua + ub + int'(rcin);
      sres = sa + sb + int'(rcin);
      rc   = (ures > 255);
    end
    rs = ures[7:0];
    rv = (sres > 127) || (sres < -128);
    return {rs, rc, rv};
  endfunction

  // Runs one operation; reports latency in edges (E0 counted as 1), busy cycles, output stability
  // while busy, and whether done dropped again on the following edge.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                       input logic isub, output logic [9:0] res, output int lat,
                       output int busy_n, output bit stable, output bit pulse_ok);
    logic [9:0] prev;
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
    prev = {sum, cout, overflow};
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom_range(0, 1));
    sub   = 1'($urandom_range(0, 1));
    lat    = 1;
    busy_n = 0;
    stable = 1'b1;
    while (lat < 20 && !done) begin
      if (busy) busy_n++;
      if ({sum, cout, overflow} !== prev) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    res = {sum, cout, overflow};
    @(posedge clk);
    #1;
    pulse_ok = !done && !busy && ({sum, cout, overflow} === res);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] res, exp, last_res;
    int         lat, busy_n, dn, busy_after, done_in_rst;
    bit         stable, pulse_ok, seen_done;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("reset_outputs", {busy, done, sum, cout, overflow}, 11'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, res, lat, busy_n, stable, pulse_ok);
      check($sformatf("vec%0d_result", i), res, {vecs[i].esum, vecs[i].ecout, vecs[i].eovf});
      check($sformatf("vec%0d_latency", i), lat, 9);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 8);
      check($sformatf("vec%0d_stable_while_busy", i), stable, 1);
      check($sformatf("vec%0d_single_done", i), pulse_ok, 1);
    end

    // start re-pulsed during RUN and during DONE must both be dropped
    dn = 0; busy_after = 0; seen_done = 1'b0;
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (seen_done && busy) busy_after++;
      if (done) begin
        dn++;
        if (!seen_done) begin
          seen_done = 1'b1;
          check("ignore_start_result", {sum, cout, overflow}, {8'h10, 1'b0, 1'b0});
          @(negedge clk);
          a = 8'h33; b = 8'h44; cin = 1'b0; sub = 1'b0; start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
          if (busy) busy_after++;
        end
      end
    end
    check("ignore_start_done_count", dn, 1);
    check("ignore_start_no_restart", busy_after, 0);
    check("ignore_start_result_held", {sum, cout, overflow}, {8'h10, 1'b0, 1'b0});

    // reset in the 4th RUN cycle aborts the operation
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_reset_outputs", {busy, done, sum, cout, overflow}, 11'h0);
    done_in_rst = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done || busy) done_in_rst++;
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    if (done || busy) done_in_rst++;
    check("abort_no_done", done_in_rst, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, res, lat, busy_n, stable, pulse_ok);
    check("after_reset_result", res, {8'h80, 1'b0, 1'b1});
    check("after_reset_latency", lat, 9);
    last_res = res;

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      int         gap;
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        check($sformatf("rand%0d_hold", n), {sum, cout, overflow}, last_res);
      end
      exp = ref_op(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, res, lat, busy_n, stable, pulse_ok);
      check($sformatf("rand%0d_result a=%0h b=%0h cin=%0b sub=%0b", n, ra, rb, rc, rs), res, exp);
      check($sformatf("rand%0d_latency", n), lat, 9);
      check($sformatf("rand%0d_stable_while_busy", n), stable, 1);
      check($sformatf("rand%0d_single_done", n), pulse_ok, 1);
      last_res = exp;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
